hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter NSRC, default 2, number of source-operand ports per instruction.
REQ-003 Parameter CW, default 16, width of the stall counter.
REQ-004 Parameter MAX_STALL, default 4, consecutive-stall limit before error.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 fwd_en  input  1  1 = forwarding mode; 0 = stall-only interlock mode.
REQ-008 id_src  input  NSRC*AW  IF/ID source registers; slice i = [i*AW +: AW].
REQ-009 id_use  input  NSRC  per-source valid; unused sources never cause a hazard.
REQ-010 id_branch  input  1  instruction in ID is a branch compared in ID.
REQ-011 ex_src  input  NSRC*AW  ID/EX source registers.
REQ-012 ex_regwrite, ex_memread  input  1 each; ex_wreg  input  AW  ID/EX producer.
REQ-013 mem_regwrite, mem_memread  input  1 each; mem_wreg  input  AW  EX/MEM producer.
REQ-014 wb_regwrite  input  1; wb_wreg  input  AW  MEM/WB producer.
REQ-015 err_clr  input  1  clears sticky error.
REQ-016 ex_fwd_sel  output  2*NSRC  ALU operand mux selects; 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-017 id_fwd_sel  output  2*NSRC  ID comparator mux selects; same encoding.
REQ-018 stall  output  1  hold PC and IF/ID.
REQ-019 flush  output  1  insert bubble into ID/EX.
REQ-020 stall_cnt  output  CW  total stall cycles, saturating.
REQ-021 err  output  1  sticky stall-limit violation.

Function
REQ-022 A producer matches source s when its regwrite=1, its wreg!=0 and wreg equals source s; register 0 never matches.
REQ-023 ex_fwd_sel slice s (fwd_en=1): 10 if mem_* matches ex_src s, else 01 if wb_* matches, else 00; each slice evaluated independently.
REQ-024 id_fwd_sel slice s (fwd_en=1, id_branch=1, id_use[s]=1): 10 if mem_* matches and mem_memread=0, else 01 if wb_* matches, else 00; 00 when id_branch=0.
REQ-025 When fwd_en=0 all select slices SHALL be 00.
REQ-026 Hazard (fwd_en=1), any used id_src s: (a) ex_memread=1 and ex_* matches; (b) id_branch=1 and ex_* matches; (c) id_branch=1, mem_memread=1 and mem_* matches.
REQ-027 Hazard (fwd_en=0), any used id_src s: ex_*, mem_* or wb_* matches (regfile write-before-read not assumed).
REQ-028 stall and flush SHALL equal the hazard term combinationally in the same cycle; flush=stall always.
REQ-029 Multi-cycle stalls (load then dependent branch = 2 cycles) arise from re-evaluation each cycle; no stall is inserted without a current hazard.
REQ-030 FSM states RUN, STALL, ERROR; RUN->STALL on stall=1; STALL->RUN on stall=0; STALL->ERROR when run_len reaches MAX_STALL with stall=1; ERROR->RUN on err_clr=1.
REQ-031 run_len (internal) increments each stall cycle, clears on stall=0; saturates at MAX_STALL.
REQ-032 stall_cnt increments by 1 each clock with stall=1; holds at 2^CW-1.
REQ-033 err=1 exactly while in ERROR; forwarding and stall outputs remain functional in ERROR.
REQ-034 err_clr together with a continuing stall: ERROR->RUN, run_len cleared, counting restarts next cycle.

Reset
REQ-035 While reset_n=0 at a clock edge: state RUN, run_len 0, stall_cnt 0, err 0.
REQ-036 While reset_n=0, stall, flush, ex_fwd_sel and id_fwd_sel SHALL be forced to 0 regardless of inputs; reset mid-stall aborts the stall.

Verification
REQ-037 fwd_en=1, mem_regwrite=1 mem_wreg=8, wb_regwrite=1 wb_wreg=8, ex_src={8,8} -> ex_fwd_sel=4'b1010, stall=0.
REQ-038 ex_memread=1 ex_regwrite=1 ex_wreg=5, id_src slice0=5 id_use=01 -> stall=flush=1 one cycle; stall_cnt 0->1.
REQ-039 Load to r3 in EX, id_branch=1 on r3; advance pipeline -> stall 2 cycles, then id_fwd_sel slice=01, stall_cnt=2.
REQ-040 Producer wreg=0 with regwrite=1 matching id_src=0 -> all selects 00, stall=0.
REQ-041 MAX_STALL=4, hold hazard 5 cycles -> err=1 from cycle 5; err_clr pulse -> err=0 next cycle.
REQ-042 fwd_en=0, wb_wreg=9 wb_regwrite=1, id_src=9 used -> stall=1, all selects 00; reset_n=0 same cycle -> stall=0, stall_cnt=0 after edge.

Source files
------------

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_forward_unit                                        |
// | Description : Pipeline hazard detection and operand-forwarding control.  |
// |               Drives EX and ID forwarding mux selects, load-use and      |
// |               branch-compare interlocks, a saturating stall counter and  |
// |               a sticky error when a stall lasts too long.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_forward_unit #(
  parameter int AW        = 5,
  parameter int NSRC      = 2,
  parameter int CW        = 16,
  parameter int MAX_STALL = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fwd_en,
  // Instruction in ID
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_use,
  input  logic                 id_branch,
  // Instruction in EX
  input  logic [NSRC*AW-1:0]   ex_src,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic [AW-1:0]        ex_wreg,
  // Instruction in MEM
  input  logic                 mem_regwrite,
  input  logic                 mem_memread,
  input  logic [AW-1:0]        mem_wreg,
  // Instruction in WB
  input  logic                 wb_regwrite,
  input  logic [AW-1:0]        wb_wreg,
  input  logic                 err_clr,
  output logic [2*NSRC-1:0]    ex_fwd_sel,
  output logic [2*NSRC-1:0]    id_fwd_sel,
  output logic                 stall,
  output logic                 flush,
  output logic [CW-1:0]        stall_cnt,
  output logic                 err
);

  // Width of the consecutive-stall run counter; it only needs to reach MAX_STALL.
  localparam int              RLW    = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RLW-1:0]  RL_MAX = RLW'(MAX_STALL);

  // Mux select encodings shared by the EX and ID operand muxes.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RLW-1:0]  run_len_q, run_len_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic [2*NSRC-1:0] ex_sel_w;
  logic [2*NSRC-1:0] id_sel_w;
  logic [NSRC-1:0]   src_haz_w;
  logic              hazard_w;

  // A producer feeds a source only if it writes a non-zero register equal to it.
  function automatic logic f_match(input logic          we,
                                   input logic [AW-1:0] wreg,
                                   input logic [AW-1:0] src);
    return we && (wreg != '0) && (wreg == src);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [AW-1:0] id_s;
      logic [AW-1:0] ex_s;
      logic          ex_id_m;
      logic          mem_id_m;
      logic          wb_id_m;
      logic          mem_ex_m;
      logic          wb_ex_m;
      logic          haz_fwd;
      logic          haz_lock;

      assign id_s     = id_src[gi*AW +: AW];
      assign ex_s     = ex_src[gi*AW +: AW];

      assign ex_id_m  = f_match(ex_regwrite,  ex_wreg,  id_s);
      assign mem_id_m = f_match(mem_regwrite, mem_wreg, id_s);
      assign wb_id_m  = f_match(wb_regwrite,  wb_wreg,  id_s);
      assign mem_ex_m = f_match(mem_regwrite, mem_wreg, ex_s);
      assign wb_ex_m  = f_match(wb_regwrite,  wb_wreg,  ex_s);

      // ALU operand: youngest producer (EX/MEM) wins over MEM/WB.
      assign ex_sel_w[2*gi +: 2] = !fwd_en  ? SEL_RF  :
                                   mem_ex_m ? SEL_MEM :
                                   wb_ex_m  ? SEL_WB  : SEL_RF;

      // Branch comparator in ID: a load in MEM has no data yet, so it cannot forward.
      assign id_sel_w[2*gi +: 2] = (!fwd_en || !id_branch || !id_use[gi]) ? SEL_RF  :
                                   (mem_id_m && !mem_memread)              ? SEL_MEM :
                                   wb_id_m                                 ? SEL_WB  : SEL_RF;

      // Forwarding mode: only load-use and branch-in-ID dependencies must wait.
      assign haz_fwd  = (ex_id_m && ex_memread) ||
                        (ex_id_m && id_branch) ||
                        (mem_id_m && id_branch && mem_memread);

      // Interlock-only mode: any in-flight writer of the source must retire first,
      // including WB since the register file is not assumed write-before-read.
      assign haz_lock = ex_id_m || mem_id_m || wb_id_m;

      assign src_haz_w[gi] = id_use[gi] && (fwd_en ? haz_fwd : haz_lock);
    end
  endgenerate

  assign hazard_w = |src_haz_w;

  // Combinational outputs are forced quiet while reset is asserted.
  assign stall      = reset_n && hazard_w;
  assign flush      = stall;
  assign ex_fwd_sel = reset_n ? ex_sel_w : '0;
  assign id_fwd_sel = reset_n ? id_sel_w : '0;
  assign stall_cnt  = stall_cnt_q;
  assign err        = (state_q == ST_ERROR);

  // Next-state logic for the stall supervisor and its run/total counters.
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!stall) begin
          state_d = ST_RUN;
        end else if (run_len_q == RL_MAX) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (err_clr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Run length restarts on a clear, even if the stall continues.
    if ((state_q == ST_ERROR) && err_clr) begin
      run_len_d = '0;
    end else if (!stall) begin
      run_len_d = '0;
    end else if (run_len_q != RL_MAX) begin
      run_len_d = run_len_q + RLW'(1);
    end

    // Total stall cycles, pinned at all-ones once full.
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      run_len_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_forward_unit                                     |
// | Description : Directed self-checking bench for hazard_forward_unit.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hazard_forward_unit;

  localparam int AW   = 5;
  localparam int NSRC = 2;

  logic                clk;
  logic                reset_n;
  logic                fwd_en;
  logic [NSRC*AW-1:0]  id_src;
  logic [NSRC-1:0]     id_use;
  logic                id_branch;
  logic [NSRC*AW-1:0]  ex_src;
  logic                ex_regwrite, ex_memread;
  logic [AW-1:0]       ex_wreg;
  logic                mem_regwrite, mem_memread;
  logic [AW-1:0]       mem_wreg;
  logic                wb_regwrite;
  logic [AW-1:0]       wb_wreg;
  logic                err_clr;
  logic [2*NSRC-1:0]   ex_fwd_sel, id_fwd_sel;
  logic                stall, flush, err;
  logic [15:0]         stall_cnt;
  logic [2*NSRC-1:0]   s_ex_fwd_sel, s_id_fwd_sel;
  logic                s_stall, s_flush, s_err;
  logic [2:0]          s_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_forward_unit #(.AW(AW), .NSRC(NSRC), .CW(16), .MAX_STALL(4)) dut (
    .clk(clk), .reset_n(reset_n), .fwd_en(fwd_en),
    .id_src(id_src), .id_use(id_use), .id_branch(id_branch),
    .ex_src(ex_src), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .err_clr(err_clr),
    .ex_fwd_sel(ex_fwd_sel), .id_fwd_sel(id_fwd_sel), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .err(err)
  );

  // Narrow-counter instance to reach saturation quickly.
  hazard_forward_unit #(.AW(AW), .NSRC(NSRC), .CW(3), .MAX_STALL(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .fwd_en(fwd_en),
    .id_src(id_src), .id_use(id_use), .id_branch(id_branch),
    .ex_src(ex_src), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_wreg(mem_wreg),
    .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg), .err_clr(err_clr),
    .ex_fwd_sel(s_ex_fwd_sel), .id_fwd_sel(s_id_fwd_sel), .stall(s_stall), .flush(s_flush),
    .stall_cnt(s_stall_cnt), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fwd_en = 1'b1; id_src = '0; id_use = '0; id_branch = 1'b0; ex_src = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_wreg = '0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_wreg = '0;
    wb_regwrite = 1'b0; wb_wreg = '0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fwd_en = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd5;
    id_src = {5'd0, 5'd5}; id_use = 2'b01; id_branch = 1'b1;
    mem_regwrite = 1'b1; mem_wreg = 5'd8; ex_src = {5'd8, 5'd8};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
    n_tests++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rst_exsel: got %b want 0000", ex_fwd_sel); end
    n_tests++; if (id_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rst_idsel: got %b want 0000", id_fwd_sel); end
    tick();
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_ex_forward();
    do_reset();
    mem_regwrite = 1'b1; mem_wreg = 5'd8; wb_regwrite = 1'b1; wb_wreg = 5'd8;
    ex_src = {5'd8, 5'd8};
    #1;
    n_tests++; if (ex_fwd_sel !== 4'b1010) begin n_fail++; $display("FAIL exf_both_mem: got %b want 1010", ex_fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exf_stall: got %b want 0", stall); end
    tick();
    wb_wreg = 5'd9; ex_src = {5'd8, 5'd9};
    #1;
    n_tests++; if (ex_fwd_sel !== 4'b1001) begin n_fail++; $display("FAIL exf_mixed: got %b want 1001", ex_fwd_sel); end
    tick();
    ex_src = {5'd3, 5'd3};
    #1;
    n_tests++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL exf_none: got %b want 0000", ex_fwd_sel); end
    tick();
    fwd_en = 1'b0; ex_src = {5'd8, 5'd9};
    #1;
    n_tests++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL exf_disabled: got %b want 0000", ex_fwd_sel); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd5;
    id_src = {5'd0, 5'd5}; id_use = 2'b01;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL lu_flush: got %b want 1", flush); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
    tick();
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
    // Load advances to MEM; a non-branch consumer forwards, no stall.
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = '0;
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_wreg = 5'd5;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", stall); end
    tick();
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
    // Unused source never causes a hazard.
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd5;
    id_src = {5'd0, 5'd5}; id_use = 2'b10;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_load_branch();
    do_reset();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd3;
    id_branch = 1'b1; id_src = {5'd0, 5'd3}; id_use = 2'b01;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall1: got %b want 1", stall); end
    tick();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wreg = '0;
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_wreg = 5'd3;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lb_stall2: got %b want 1", stall); end
    n_tests++; if (id_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL lb_idsel_load: got %b want 0000", id_fwd_sel); end
    tick();
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_wreg = '0;
    wb_regwrite = 1'b1; wb_wreg = 5'd3;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb_release: got %b want 0", stall); end
    n_tests++; if (id_fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL lb_idsel_wb: got %b want 0001", id_fwd_sel); end
    n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lb_cnt: got %0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_id_forward();
    do_reset();
    id_branch = 1'b1; id_src = {5'd0, 5'd3}; id_use = 2'b01;
    mem_regwrite = 1'b1; mem_wreg = 5'd3; wb_regwrite = 1'b1; wb_wreg = 5'd3;
    #1;
    n_tests++; if (id_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL idf_mem: got %b want 0010", id_fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL idf_stall: got %b want 0", stall); end
    tick();
    id_branch = 1'b0;
    #1;
    n_tests++; if (id_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL idf_nobranch: got %b want 0000", id_fwd_sel); end
    tick();
  endtask

  task automatic test_reg_zero();
    do_reset();
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = '0;
    mem_regwrite = 1'b1; mem_wreg = '0; wb_regwrite = 1'b1; wb_wreg = '0;
    id_src = '0; id_use = 2'b11; id_branch = 1'b1; ex_src = '0;
    #1;
    n_tests++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL r0_exsel: got %b want 0000", ex_fwd_sel); end
    n_tests++; if (id_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL r0_idsel: got %b want 0000", id_fwd_sel); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
    fwd_en = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_lock_stall: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_stall_limit();
    do_reset();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd5;
    id_src = {5'd0, 5'd5}; id_use = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++;
      if (err !== (k >= 5)) begin n_fail++; $display("FAIL lim_err_edge%0d: got %b want %b", k, err, (k >= 5)); end
    end
    n_tests++; if (s_stall_cnt !== 3'd5) begin n_fail++; $display("FAIL lim_scnt5: got %0d want 5", s_stall_cnt); end
    // Still functional while in error.
    mem_regwrite = 1'b1; mem_wreg = 5'd7; ex_src = {5'd0, 5'd7};
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lim_err_stall: got %b want 1", stall); end
    n_tests++; if (ex_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL lim_err_exsel: got %b want 0010", ex_fwd_sel); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL lim_clr: got %b want 0", err); end
    // Hazard never dropped: the run restarts from zero after the clear.
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_tests++;
      if (err !== (k >= 5)) begin n_fail++; $display("FAIL lim_rerun_edge%0d: got %b want %b", k, err, (k >= 5)); end
    end
    n_tests++; if (stall_cnt !== 16'd11) begin n_fail++; $display("FAIL lim_cnt: got %0d want 11", stall_cnt); end
    n_tests++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL lim_sat: got %0d want 7", s_stall_cnt); end
    idle();
    tick();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL lim_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL lim_clr2: got %b want 0", err); end
  endtask

  task automatic test_interlock();
    do_reset();
    fwd_en = 1'b0; wb_regwrite = 1'b1; wb_wreg = 5'd9;
    id_src = {5'd9, 5'd0}; id_use = 2'b10; id_branch = 1'b1; ex_src = {5'd9, 5'd9};
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL il_stall: got %b want 1", stall); end
    n_tests++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL il_exsel: got %b want 0000", ex_fwd_sel); end
    n_tests++; if (id_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL il_idsel: got %b want 0000", id_fwd_sel); end
    tick();
    n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL il_cnt1: got %0d want 1", stall_cnt); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL il_rst_stall: got %b want 0", stall); end
    tick();
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL il_rst_cnt: got %0d want 0", stall_cnt); end
    reset_n = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL il_restall: got %b want 1", stall); end
    // Same dependency in forwarding mode resolves through the register file / WB path.
    fwd_en = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL il_fwd_stall: got %b want 0", stall); end
    n_tests++; if (ex_fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL il_fwd_exsel: got %b want 0101", ex_fwd_sel); end
    tick();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    test_reset();
    test_ex_forward();
    test_load_use();
    test_load_branch();
    test_id_forward();
    test_reg_zero();
    test_stall_limit();
    test_interlock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
